spike_event_packetizer: RTL and testbench
=========================================

Name: spike_event_packetizer

Overview:
- Downstream of the processing system. Consumes the per-unit spike and event arrays every cycle and timestamps any non-idle cycle with a sample counter.
- Buffers snapshots in a small FIFO and serializes each one as a 4-byte packet over a byte-wide valid/ready stream, for the top level to drive onto the uio pins.
- Makes every unit's activity visible off-chip, not only the one selected unit.

Parameters:
- NUM_UNITS, 4, number of detector units. The packet format is fixed for 4.
- EVT_WIDTH, 2, event code bits per unit.
- TS_WIDTH, 16, timestamp width in samples.
- FIFO_DEPTH, 4, snapshot entries. Must be a power of 2, at least 2.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- enable  in  1  when 0, no snapshots are captured; the timestamp still counts.
- sample_strobe  in  1  one-cycle pulse per completed input sample (the same pulse that writes the processing system).
- spike_detection_array  in  NUM_UNITS  per-unit spike flags.
- event_out_array  in  NUM_UNITS*EVT_WIDTH  per-unit event codes; 2'b00 means no event.
- out_byte  out  8  packet byte.
- out_valid  out  1  out_byte is valid.
- out_ready  in  1  consumer accepts the byte on this edge.
- out_last  out  1  marks the final byte of a packet.
- overflow  out  1  sticky: a snapshot was dropped.
- drop_count  out  8  number of dropped snapshots, saturating.
- clear_status  in  1  clears overflow and drop_count.

Behaviour:
- Reset: all outputs 0. Timestamp 0, FIFO empty, FSM in IDLE.
- Timestamp (ts):
  - Increments by 1 on each clock with sample_strobe=1.
  - Wraps from 0xFFFF to 0x0000.
- Activity and capture:
  - A cycle is active when enable=1 AND (any spike bit=1 OR any event code != 0).
  - On an active edge, push the snapshot {spike[3:0], event[7:0], ts}.
  - ts is the value before that edge's increment.
- Packet format, sent in this order:
  - B0 = {4'hA, spike[3:0]}.
  - B1 = event[7:0], with unit 0 in bits [1:0].
  - B2 = ts[15:8].
  - B3 = ts[7:0], with out_last=1.
- FIFO push/pop rules:
  - Full and empty are based on the pre-edge occupancy.
  - A push while full is accepted only if a pop occurs on the same edge; otherwise it is dropped.
  - A drop sets overflow and increments drop_count, saturating at 0xFF.
  - Push and pop on the same edge leave the occupancy unchanged.
  - clear_status takes priority over a drop on the same edge: the result is overflow=0 and drop_count=0.
- Serializer FSM: states IDLE, B0, B1, B2, B3.
  - IDLE: if the FIFO is not empty, pop the head into the shift register and go to B0.
  - Bn with out_valid=1: advance only on out_valid&&out_ready. From B3, go to B0 if the FIFO is not empty (popping the next entry on that same edge); otherwise go to IDLE.
  - While stalled, out_byte and out_last are held stable.
  - out_valid is 1 in states B0..B3 and 0 in IDLE.
- Latency:
  - Active input at edge k is written at edge k.
  - If the FIFO was empty and the FSM was in IDLE, the pop happens at edge k+1 and B0 is presented after edge k+1.
  - With out_ready held at 1, back-to-back packets carry no idle gap.
- Ordering: packets leave in capture order and are never reordered or split.
- enable only gates capture. A packet already in flight completes normally.
- Reset mid-packet: the packet is abandoned and out_valid drops immediately (asynchronous).

Decomposition:
- Shared package holds:
  - PKT_HDR = 4'hA and PKT_BYTES = 4.
  - Snapshot struct {spike, event, ts}, width 28.
  - FSM state enum.
- One sub-module, snapshot_fifo: a synchronous FIFO with a parameterized width/depth and a same-edge push-while-full-with-pop rule.

Test Plan:
- Single spike: reset, assert sample_strobe 3 times, then spike=4'b0010 with events 0. Required: bytes A2,00,00,03; out_last only on 03; out_valid rises after the edge following capture.
- Events plus wrap: preload ts to 0xFFFF via 65535 strobes, then capture events=8'b01_00_00_11 with a strobe on the same cycle. Required: bytes A0,43,FF,FF. The next capture carries ts 0x0000.
- Backpressure: hold out_ready=0 for 5 cycles during B1. Required: out_byte stays at the B1 value with out_valid=1, then the packet resumes without byte loss.
- Overflow: out_ready=0, 6 consecutive active cycles. Required: 4 stored, overflow=1, drop_count=2. Then release; exactly 4 packets in order. clear_status returns both to 0.
- Simultaneous push while full with pop: FIFO full, pop and active input on the same edge. Required: no drop, occupancy stays 4.
- Reset mid-packet: assert rst_n=0 during B2. Required: out_valid=0 immediately. After release there is no residual packet and ts=0.

Source files
------------

// File: rtl/spike_event_packetizer_pkg.sv
// Shared types for the spike/event packetizer: packet constants, snapshot layout
// and serializer state encoding.
package spike_event_packetizer_pkg;

    localparam logic [3:0] PKT_HDR   = 4'hA;
    localparam int         PKT_BYTES = 4;
    localparam int         SNAP_W    = 28;

    typedef struct packed {
        logic [3:0]  spike;
        logic [7:0]  evt;
        logic [15:0] ts;
    } snapshot_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_B0,
        ST_B1,
        ST_B2,
        ST_B3
    } state_e;

endpackage

// File: rtl/snapshot_fifo.sv
// Synchronous snapshot FIFO; a push while full is accepted only when a pop
// happens on the same edge, otherwise it is reported on drop_o.
module snapshot_fifo #(
    parameter int WIDTH = 28,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             empty_o,
    output logic             drop_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (count_q == '0);
    assign full    = (count_q == (AW+1)'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    // Full/empty come from pre-edge occupancy, so a same-edge pop frees a slot.
    assign do_push = push_i && (!full || do_pop);
    assign drop_o  = push_i && !do_push;
    assign dout_o  = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

endmodule

// File: rtl/spike_event_packetizer.sv
// Timestamps active spike/event cycles, buffers the snapshots and serializes
// each one as a 4-byte packet on a byte-wide valid/ready stream.
module spike_event_packetizer
    import spike_event_packetizer_pkg::*;
#(
    parameter int NUM_UNITS  = 4,
    parameter int EVT_WIDTH  = 2,
    parameter int TS_WIDTH   = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           enable,
    input  logic                           sample_strobe,
    input  logic [NUM_UNITS-1:0]           spike_detection_array,
    input  logic [NUM_UNITS*EVT_WIDTH-1:0] event_out_array,
    output logic [7:0]                     out_byte,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic                           out_last,
    output logic                           overflow,
    output logic [7:0]                     drop_count,
    input  logic                           clear_status
);

    logic [TS_WIDTH-1:0] ts_q;
    state_e              state_q, state_d;
    snapshot_t           pkt_q;
    snapshot_t           snap_in;
    snapshot_t           fifo_dout;
    logic                fifo_empty;
    logic                fifo_drop;
    logic                active;
    logic                pop;
    logic                fire;
    logic                overflow_q;
    logic [7:0]          drop_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)             ts_q <= '0;
        else if (sample_strobe) ts_q <= ts_q + TS_WIDTH'(1);
    end

    // The snapshot carries the timestamp as it was before this edge's increment.
    assign active        = enable && ((|spike_detection_array) || (|event_out_array));
    assign snap_in.spike = spike_detection_array;
    assign snap_in.evt   = event_out_array;
    assign snap_in.ts    = ts_q;

    snapshot_fifo #(
        .WIDTH (SNAP_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (active),
        .pop_i   (pop),
        .din_i   (snap_in),
        .dout_o  (fifo_dout),
        .empty_o (fifo_empty),
        .drop_o  (fifo_drop)
    );

    assign out_valid = (state_q != ST_IDLE);
    assign out_last  = (state_q == ST_B3);
    assign fire      = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            ST_IDLE: if (!fifo_empty) begin
                pop     = 1'b1;
                state_d = ST_B0;
            end
            ST_B0: if (fire) state_d = ST_B1;
            ST_B1: if (fire) state_d = ST_B2;
            ST_B2: if (fire) state_d = ST_B3;
            // Chaining straight into the next B0 keeps back-to-back packets gap-free.
            ST_B3: if (fire) begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = ST_B0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (pop) pkt_q <= fifo_dout;
    end

    always_comb begin
        out_byte = 8'h00;
        case (state_q)
            ST_B0:   out_byte = {PKT_HDR, pkt_q.spike};
            ST_B1:   out_byte = pkt_q.evt;
            ST_B2:   out_byte = pkt_q.ts[15:8];
            ST_B3:   out_byte = pkt_q.ts[7:0];
            default: out_byte = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q <= 1'b0;
            drop_cnt_q <= 8'h00;
        end else if (clear_status) begin
            overflow_q <= 1'b0;
            drop_cnt_q <= 8'h00;
        end else if (fifo_drop) begin
            overflow_q <= 1'b1;
            if (drop_cnt_q != 8'hFF) drop_cnt_q <= drop_cnt_q + 8'h01;
        end
    end

    assign overflow   = overflow_q;
    assign drop_count = drop_cnt_q;

endmodule

// File: tb/tb_spike_event_packetizer.sv
// Directed bench for spike_event_packetizer: table of single-packet captures
// plus hand-written backpressure, overflow, wrap and mid-packet reset sequences.
module tb_spike_event_packetizer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic       sample_strobe;
    logic [3:0] spike;
    logic [7:0] evt;
    logic [7:0] out_byte;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;
    logic       overflow;
    logic [7:0] drop_count;
    logic       clear_status;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0]  spike;
        logic [7:0]  evt;
        logic        strobe;
        logic [31:0] pkt;
    } vec_t;

    vec_t vecs[4];

    always #5 clk = ~clk;

    spike_event_packetizer dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .enable                (enable),
        .sample_strobe         (sample_strobe),
        .spike_detection_array (spike),
        .event_out_array       (evt),
        .out_byte              (out_byte),
        .out_valid             (out_valid),
        .out_ready             (out_ready),
        .out_last              (out_last),
        .overflow              (overflow),
        .drop_count            (drop_count),
        .clear_status          (clear_status)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input logic [3:0] sp, input logic [7:0] ev, input logic st);
        spike         = sp;
        evt           = ev;
        sample_strobe = st;
        enable        = 1'b1;
        tick();
        spike         = 4'h0;
        evt           = 8'h00;
        sample_strobe = 1'b0;
    endtask

    // Expects the FSM to be presenting B0 now; consumes all four bytes.
    task automatic collect(input string name, input logic [31:0] pkt);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("%s valid b%0d", name, i), {31'd0, out_valid}, 32'd1);
            chk($sformatf("%s byte b%0d", name, i), {24'd0, out_byte}, {24'd0, pkt[31-8*i -: 8]});
            chk($sformatf("%s last b%0d", name, i), {31'd0, out_last}, (i == 3) ? 32'd1 : 32'd0);
            tick();
        end
    endtask

    initial begin
        rst_n         = 1'b0;
        enable        = 1'b0;
        sample_strobe = 1'b0;
        spike         = 4'h0;
        evt           = 8'h00;
        out_ready     = 1'b0;
        clear_status  = 1'b0;
        tick();
        tick();
        chk("rst out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst out_byte", {24'd0, out_byte}, 32'd0);
        chk("rst out_last", {31'd0, out_last}, 32'd0);
        chk("rst overflow", {31'd0, overflow}, 32'd0);
        chk("rst drop_count", {24'd0, drop_count}, 32'd0);
        rst_n = 1'b1;
        tick();

        sample_strobe = 1'b1;
        repeat (3) tick();
        sample_strobe = 1'b0;

        vecs[0] = '{spike: 4'b0010, evt: 8'h00, strobe: 1'b0, pkt: 32'hA2_00_00_03};
        vecs[1] = '{spike: 4'b1111, evt: 8'hE4, strobe: 1'b1, pkt: 32'hAF_E4_00_03};
        vecs[2] = '{spike: 4'b0000, evt: 8'h01, strobe: 1'b0, pkt: 32'hA0_01_00_04};
        vecs[3] = '{spike: 4'b1000, evt: 8'h00, strobe: 1'b1, pkt: 32'hA8_00_00_04};

        out_ready = 1'b1;
        for (int v = 0; v < 4; v++) begin
            apply(vecs[v].spike, vecs[v].evt, vecs[v].strobe);
            chk($sformatf("vec%0d valid after capture edge", v), {31'd0, out_valid}, 32'd0);
            tick();
            collect($sformatf("vec%0d", v), vecs[v].pkt);
            chk($sformatf("vec%0d idle after packet", v), {31'd0, out_valid}, 32'd0);
        end

        // Disabled capture: no packet, timestamp still advances (ts -> 6).
        enable        = 1'b0;
        spike         = 4'b0001;
        sample_strobe = 1'b1;
        tick();
        spike         = 4'h0;
        sample_strobe = 1'b0;
        enable        = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("disabled no packet", {31'd0, out_valid}, 32'd0);
            tick();
        end

        // Backpressure stall in B1.
        out_ready = 1'b0;
        apply(4'b0100, 8'h10, 1'b0);
        tick();
        chk("bp b0 byte", {24'd0, out_byte}, 32'hA4);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("bp stall valid", {31'd0, out_valid}, 32'd1);
            chk("bp stall byte", {24'd0, out_byte}, 32'h10);
            tick();
        end
        out_ready = 1'b1;
        chk("bp resume b1", {24'd0, out_byte}, 32'h10);
        tick();
        chk("bp b2", {24'd0, out_byte}, 32'h00);
        tick();
        chk("bp b3", {24'd0, out_byte}, 32'h06);
        chk("bp b3 last", {31'd0, out_last}, 32'd1);
        tick();
        chk("bp idle", {31'd0, out_valid}, 32'd0);

        // Overflow: serializer holds c0, then six captures fill 4 entries and drop 2.
        out_ready = 1'b0;
        apply(4'b1111, 8'h00, 1'b0);
        tick();
        for (int i = 1; i <= 6; i++) apply(4'(i), 8'h00, 1'b0);
        chk("ovf overflow", {31'd0, overflow}, 32'd1);
        chk("ovf drop_count", {24'd0, drop_count}, 32'd2);
        chk("ovf held b0", {24'd0, out_byte}, 32'hAF);
        out_ready = 1'b1;
        tick();
        chk("ovf c0 b1", {24'd0, out_byte}, 32'h00);
        tick();
        tick();
        chk("ovf c0 b3", {24'd0, out_byte}, 32'h06);
        chk("ovf c0 last", {31'd0, out_last}, 32'd1);
        // Full FIFO: the B3 pop and a new capture share this edge.
        apply(4'b0111, 8'h00, 1'b0);
        chk("push+pop no drop", {24'd0, drop_count}, 32'd2);
        collect("ovf c1", 32'hA1_00_00_06);
        collect("ovf c2", 32'hA2_00_00_06);
        collect("ovf c3", 32'hA3_00_00_06);
        collect("ovf c4", 32'hA4_00_00_06);
        collect("ovf c7", 32'hA7_00_00_06);
        chk("ovf drained", {31'd0, out_valid}, 32'd0);
        clear_status = 1'b1;
        tick();
        clear_status = 1'b0;
        chk("clear overflow", {31'd0, overflow}, 32'd0);
        chk("clear drop_count", {24'd0, drop_count}, 32'd0);

        // Timestamp wrap: 6 + 65529 strobes reaches 0xFFFF.
        sample_strobe = 1'b1;
        repeat (65529) tick();
        sample_strobe = 1'b0;
        apply(4'b0000, 8'b01_00_00_11, 1'b1);
        tick();
        collect("wrap ffff", 32'hA0_43_FF_FF);
        apply(4'b0001, 8'h00, 1'b0);
        tick();
        collect("wrap 0000", 32'hA1_00_00_00);

        // Reset in B2 with a few strobes so ts is non-zero beforehand.
        apply(4'b0010, 8'h00, 1'b1);
        sample_strobe = 1'b1;
        tick();
        tick();
        sample_strobe = 1'b0;
        tick();
        chk("mid b2 valid", {31'd0, out_valid}, 32'd1);
        out_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("async rst valid", {31'd0, out_valid}, 32'd0);
        chk("async rst byte", {24'd0, out_byte}, 32'd0);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post rst no residual", {31'd0, out_valid}, 32'd0);
        end
        apply(4'b0001, 8'h00, 1'b0);
        tick();
        collect("post rst ts0", 32'hA1_00_00_00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
